// File: rtl/mem_pkg.sv
// Shared types and widths for the MEM pipeline stage and its data RAM.
package mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned LAT_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/data_ram.sv
// Word-wide data RAM: synchronous write, asynchronous read, contents survive reset.
module data_ram
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: word load/store to a local RAM with MEM_LAT wait states,
// combinational upstream stall and registered MEM/WB outputs.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [WORD_W-1:0] data_in,
    input  logic [WORD_W-1:0] mem_addr,
    input  logic [REG_W-1:0]  rd_mem,
    output logic              stall,
    output logic              wb_valid,
    output logic [WORD_W-1:0] wb_data,
    output logic [REG_W-1:0]  rd_wb,
    output logic              misalign
);

    localparam logic [LAT_W-1:0] LAT_INIT = (MEM_LAT == 0) ? '0 : LAT_W'(MEM_LAT - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [LAT_W-1:0]  r_cnt;
    logic [LAT_W-1:0]  w_cnt_next;
    logic              w_mem_op;
    logic              w_aligned;
    logic              w_complete;
    logic              w_stall;
    logic              w_we;
    logic [ADDR_W-1:0] w_index;
    logic [WORD_W-1:0] w_rdata;

    logic              r_wb_valid;
    logic [WORD_W-1:0] r_wb_data;
    logic [REG_W-1:0]  r_rd_wb;
    logic              r_misalign;

    assign w_mem_op  = ex_valid & (mem_read | mem_write);
    assign w_aligned = (mem_addr[1:0] == 2'b00);
    assign w_index   = mem_addr[ADDR_W+1:2];
    // a simultaneous read+write request is a load, so only a pure store writes
    assign w_we      = w_complete & mem_write & ~mem_read;

    data_ram #(
        .ADDR_W (ADDR_W)
    ) u_data_ram (
        .i_clk   (clock),
        .i_we    (w_we),
        .i_waddr (w_index),
        .i_wdata (data_in),
        .i_raddr (w_index),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_complete   = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mem_op && w_aligned) begin
                    if (MEM_LAT == 0) begin
                        w_complete = 1'b1;
                    end else begin
                        w_stall      = 1'b1;
                        w_state_next = BUSY;
                        w_cnt_next   = LAT_INIT;
                    end
                end
            end
            BUSY: begin
                if (r_cnt != '0) begin
                    w_stall    = 1'b1;
                    w_cnt_next = r_cnt - LAT_W'(1);
                end else begin
                    w_complete   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign stall = w_stall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_rd_wb    <= '0;
            r_misalign <= 1'b0;
        end else if (w_complete) begin
            r_wb_valid <= 1'b1;
            r_misalign <= 1'b0;
            if (mem_read) begin
                r_wb_data <= w_rdata;
                r_rd_wb   <= rd_mem;
            end else begin
                r_rd_wb   <= '0;
            end
        end else if (r_state == BUSY || (w_mem_op && w_aligned) || !ex_valid) begin
            // wait states and bubbles both present an empty slot; data holds
            r_wb_valid <= 1'b0;
            r_rd_wb    <= '0;
            r_misalign <= 1'b0;
        end else if (!w_mem_op) begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= mem_addr;
            r_rd_wb    <= rd_mem;
            r_misalign <= 1'b0;
        end else begin
            r_wb_valid <= 1'b1;
            r_rd_wb    <= '0;
            r_misalign <= 1'b1;
        end
    end

    assign wb_valid = r_wb_valid;
    assign wb_data  = r_wb_data;
    assign rd_wb    = r_rd_wb;
    assign misalign = r_misalign;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: two instances (MEM_LAT=2 and MEM_LAT=0) against a transaction-level model.
module tb_mem_access_stage;

    localparam int unsigned LAT_A = 2;
    localparam int unsigned LAT_B = 0;

    logic        clock;
    logic        reset;

    logic        a_ev, a_rd, a_wr;
    logic [31:0] a_din, a_addr;
    logic [4:0]  a_rdm;
    logic        a_stall, a_wbv, a_mis;
    logic [31:0] a_wbd;
    logic [4:0]  a_rdwb;

    logic        b_ev, b_rd, b_wr;
    logic [31:0] b_din, b_addr;
    logic [4:0]  b_rdm;
    logic        b_stall, b_wbv, b_mis;
    logic [31:0] b_wbd;
    logic [4:0]  b_rdwb;

    int vectors;
    int miscompares;

    logic [31:0] m_ram [2][256];
    logic        m_v   [2];
    logic [31:0] m_d   [2];
    logic [4:0]  m_rd  [2];
    logic        m_mis [2];

    mem_access_stage #(.ADDR_W(8), .MEM_LAT(LAT_A)) u_lat2 (
        .clock(clock), .reset(reset), .ex_valid(a_ev), .mem_read(a_rd), .mem_write(a_wr),
        .data_in(a_din), .mem_addr(a_addr), .rd_mem(a_rdm), .stall(a_stall),
        .wb_valid(a_wbv), .wb_data(a_wbd), .rd_wb(a_rdwb), .misalign(a_mis)
    );

    mem_access_stage #(.ADDR_W(8), .MEM_LAT(LAT_B)) u_lat0 (
        .clock(clock), .reset(reset), .ex_valid(b_ev), .mem_read(b_rd), .mem_write(b_wr),
        .data_in(b_din), .mem_addr(b_addr), .rd_mem(b_rdm), .stall(b_stall),
        .wb_valid(b_wbv), .wb_data(b_wbd), .rd_wb(b_rdwb), .misalign(b_mis)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic o_stall(input int d);
        return (d == 0) ? a_stall : b_stall;
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d observed=%h expected=%h at %0t", tag, d, obs, exp, $time);
        end
    endtask

    task automatic check_outs(input int d);
        chk("wb_valid", d, {31'b0, (d == 0) ? a_wbv : b_wbv}, {31'b0, m_v[d]});
        chk("wb_data",  d, (d == 0) ? a_wbd : b_wbd, m_d[d]);
        chk("rd_wb",    d, {27'b0, (d == 0) ? a_rdwb : b_rdwb}, {27'b0, m_rd[d]});
        chk("misalign", d, {31'b0, (d == 0) ? a_mis : b_mis}, {31'b0, m_mis[d]});
    endtask

    task automatic bubbles();
        a_ev = 0; a_rd = 0; a_wr = 0; a_din = '0; a_addr = '0; a_rdm = '0;
        b_ev = 0; b_rd = 0; b_wr = 0; b_din = '0; b_addr = '0; b_rdm = '0;
    endtask

    task automatic drive(input int d, input logic ev, input logic rd, input logic wr,
                         input logic [31:0] din, input logic [31:0] addr, input logic [4:0] rdm);
        bubbles();
        if (d == 0) begin
            a_ev = ev; a_rd = rd; a_wr = wr; a_din = din; a_addr = addr; a_rdm = rdm;
        end else begin
            b_ev = ev; b_rd = rd; b_wr = wr; b_din = din; b_addr = addr; b_rdm = rdm;
        end
    endtask

    // One instruction through the stage: model decides wait count and final MEM/WB contents.
    task automatic txn(input int d, input logic ev, input logic rd, input logic wr,
                       input logic [31:0] din, input logic [31:0] addr, input logic [4:0] rdm);
        int unsigned lat;
        int unsigned waits;
        logic        memop;
        logic        al;
        int unsigned idx;
        lat   = (d == 0) ? LAT_A : LAT_B;
        memop = ev & (rd | wr);
        al    = (addr % 4 == 0);
        waits = (memop && al) ? lat : 0;
        idx   = (addr / 4) % 256;
        @(negedge clock);
        drive(d, ev, rd, wr, din, addr, rdm);
        for (int unsigned i = 0; i <= waits; i++) begin
            #1;
            chk("stall", d, {31'b0, o_stall(d)}, {31'b0, (i < waits)});
            @(posedge clock);
            #1;
            if (i < waits) begin
                m_v[d] = 0; m_rd[d] = '0; m_mis[d] = 0;
            end else if (!ev) begin
                m_v[d] = 0; m_rd[d] = '0; m_mis[d] = 0;
            end else if (!memop) begin
                m_v[d] = 1; m_d[d] = addr; m_rd[d] = rdm; m_mis[d] = 0;
            end else if (!al) begin
                m_v[d] = 1; m_rd[d] = '0; m_mis[d] = 1;
            end else if (rd) begin
                m_v[d] = 1; m_d[d] = m_ram[d][idx]; m_rd[d] = rdm; m_mis[d] = 0;
            end else begin
                m_v[d] = 1; m_rd[d] = '0; m_mis[d] = 0;
                m_ram[d][idx] = din;
            end
            check_outs(d);
        end
        m_v[1-d] = 0; m_rd[1-d] = '0; m_mis[1-d] = 0;
    endtask

    task automatic do_reset();
        bubbles();
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            m_v[d] = 0; m_d[d] = '0; m_rd[d] = '0; m_mis[d] = 0;
            check_outs(d);
            chk("stall_rst", d, {31'b0, o_stall(d)}, 32'd0);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] addr;
        int          kind;
        int          d;
        vectors     = 0;
        miscompares = 0;
        bubbles();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_v[k] = 0; m_d[k] = '0; m_rd[k] = '0; m_mis[k] = 0;
        end
        repeat (2) @(negedge clock);
        for (int k = 0; k < 2; k++) check_outs(k);
        reset = 1'b0;

        // known contents for word indices 0..15 of both RAMs
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++)
                txn(k, 1, 0, 1, $urandom, i * 4, 5'($urandom));

        txn(0, 1, 0, 0, 32'h0, 32'h0000_1234, 5'd7);
        chk("alu_data", 0, a_wbd, 32'h0000_1234);

        txn(0, 1, 0, 1, 32'hDEAD_BEEF, 32'h10, 5'd9);
        txn(0, 1, 1, 0, 32'h0, 32'h10, 5'd3);
        chk("load_beef", 0, a_wbd, 32'hDEAD_BEEF);

        txn(0, 1, 1, 0, 32'h0, 32'h13, 5'd5);
        txn(0, 1, 0, 1, 32'h1234_5678, 32'h12, 5'd2);
        txn(0, 1, 1, 0, 32'h0, 32'h10, 5'd4);
        txn(0, 1, 1, 1, 32'h0, 32'h10, 5'd6);

        txn(0, 1, 0, 0, 32'h0, 32'hCAFE_0001, 5'd31);
        #2;
        do_reset();

        @(negedge clock);
        drive(0, 1, 0, 1, 32'h55, 32'h20, 5'd1);
        #1;
        chk("stall_busy0", 0, {31'b0, a_stall}, 32'd1);
        @(posedge clock);
        #1;
        chk("stall_busy1", 0, {31'b0, a_stall}, 32'd1);
        do_reset();
        txn(0, 1, 1, 0, 32'h0, 32'h20, 5'd8);

        txn(1, 1, 0, 1, 32'hA5A5_0F0F, 32'h14, 5'd0);
        txn(1, 1, 1, 0, 32'h0, 32'h14, 5'd12);
        chk("lat0_load", 1, b_wbd, 32'hA5A5_0F0F);
        txn(1, 1, 1, 0, 32'h0, 32'h14, 5'd0);

        for (int n = 0; n < 300; n++) begin
            d    = $urandom_range(0, 1);
            kind = $urandom_range(0, 9);
            addr = $urandom;
            addr = (addr & 32'hFFFF_FC00) | ($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) addr = addr | $urandom_range(1, 3);
            case (kind)
                0:       txn(d, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, addr, 5'($urandom));
                1, 2:    txn(d, 1, 0, 0, $urandom, $urandom, 5'($urandom));
                3, 4, 5: txn(d, 1, 1, 0, $urandom, addr, 5'($urandom));
                6, 7, 8: txn(d, 1, 0, 1, $urandom, addr, 5'($urandom));
                default: txn(d, 1, 1, 1, $urandom, addr, 5'($urandom));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
